// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
//
// Memory-side responder for the cache pmem_* line interface. A 256-bit line
// read or write from a cache is turned into a 4-beat, 64-bit burst toward
// main memory. Read beats are reassembled into a full line. Write lines are
// serialised into beats, least-significant beat first.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   line_read/write   : cache request, held until line_resp
//   line_addr         : line address, bits [4:0] ignored
//   line_wdata        : write line, captured when the request is accepted
//   line_rdata        : assembled read line, stable until the next read
//   line_resp         : one-cycle completion pulse
//   burst_read/write  : memory burst request, high for the whole burst
//   burst_addr        : line-aligned burst address, registered at accept
//   burst_wdata       : current write beat
//   burst_rdata       : current read beat from memory
//   burst_resp        : one beat transferred this cycle
//   err               : sticky protocol error
//
// Optional feature: define CLADAPT_ERRCHK_EN to build the protocol checker
// behind err. Without it err is tied low and no checker logic exists.
// -----------------------------------------------------------------------------
module cacheline_adapter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         line_read,
   input  logic         line_write,
   input  logic [31:0]  line_addr,
   input  logic [255:0] line_wdata,
   output logic [255:0] line_rdata,
   output logic         line_resp,
   output logic         burst_read,
   output logic         burst_write,
   output logic [31:0]  burst_addr,
   output logic [63:0]  burst_wdata,
   input  logic [63:0]  burst_rdata,
   input  logic         burst_resp,
   output logic         err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [26:0]    addr_q, addr_d;
   logic [255:0]   buf_q, buf_d;
   logic [255:0]   line_rdata_q, line_rdata_d;

   // Offset bits within the line carry no information for a line transfer.
   logic           unused_addr_bits;
   assign unused_addr_bits = ^line_addr[4:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         addr_q       <= 27'd0;
         buf_q        <= 256'd0;
         line_rdata_q <= 256'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         buf_q        <= buf_d;
         line_rdata_q <= line_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      buf_d        = buf_q;
      line_rdata_d = line_rdata_q;
      case (state_q)
         S_IDLE: begin
            // Read has priority when both requests are raised together.
            if (line_read) begin
               addr_d  = line_addr[31:5];
               cnt_d   = 2'd0;
               state_d = S_RD;
            end else if (line_write) begin
               addr_d  = line_addr[31:5];
               buf_d   = line_wdata;
               cnt_d   = 2'd0;
               state_d = S_WR;
            end
         end
         S_RD: begin
            if (burst_resp) begin
               line_rdata_d[{cnt_q, 6'd0} +: 64] = burst_rdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_DONE;
            end
         end
         S_WR: begin
            if (burst_resp) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_DONE;
            end
         end
         S_DONE: begin
            // The cache drops its request on this edge, so IDLE is safe.
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign line_rdata  = line_rdata_q;
   assign line_resp   = (state_q == S_DONE);
   assign burst_read  = (state_q == S_RD);
   assign burst_write = (state_q == S_WR);
   assign burst_addr  = {addr_q, 5'd0};
   // Beat select straight from registered buffer and counter; gated so the
   // bus idles at zero outside a write burst.
   assign burst_wdata = (state_q == S_WR) ? buf_q[{cnt_q, 6'd0} +: 64] : 64'd0;

`ifdef CLADAPT_ERRCHK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (((state_q == S_IDLE) || (state_q == S_DONE)) && burst_resp) err_d = 1'b1;
      if ((state_q == S_IDLE) && line_read && line_write) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adapter
//
// Directed bench for cacheline_adapter. Inputs are driven and outputs are
// observed at the falling edge; the DUT acts on the rising edge. Expected
// values are hand-written constants for each step.
// -----------------------------------------------------------------------------
module tb_cacheline_adapter;

`ifdef CLADAPT_ERRCHK_EN
   localparam logic ERRCHK = 1'b1;
`else
   localparam logic ERRCHK = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         line_read;
   logic         line_write;
   logic [31:0]  line_addr;
   logic [255:0] line_wdata;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic         burst_read;
   logic         burst_write;
   logic [31:0]  burst_addr;
   logic [63:0]  burst_wdata;
   logic [63:0]  burst_rdata;
   logic         burst_resp;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_acc;

   cacheline_adapter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .line_read   (line_read),
      .line_write  (line_write),
      .line_addr   (line_addr),
      .line_wdata  (line_wdata),
      .line_rdata  (line_rdata),
      .line_resp   (line_resp),
      .burst_read  (burst_read),
      .burst_write (burst_write),
      .burst_addr  (burst_addr),
      .burst_wdata (burst_wdata),
      .burst_rdata (burst_rdata),
      .burst_resp  (burst_resp),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive four read beats on consecutive cycles, checking the burst stays up.
   task automatic read_beats(input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3);
      logic [63:0] beats [4];
      beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
      for (int k = 0; k < 4; k++) begin
         chk("rd_burst_read_high", burst_read, 1'b1);
         chk("rd_no_resp_yet", line_resp, 1'b0);
         burst_resp  = 1'b1;
         burst_rdata = beats[k];
         tick();
      end
      burst_resp  = 1'b0;
      burst_rdata = 64'd0;
   endtask

   localparam logic [63:0] A0 = 64'hA0A0_0000_0000_00A0;
   localparam logic [63:0] A1 = 64'hA1A1_1111_1111_11A1;
   localparam logic [63:0] A2 = 64'hA2A2_2222_2222_22A2;
   localparam logic [63:0] A3 = 64'hA3A3_3333_3333_33A3;
   localparam logic [63:0] D0 = 64'hD000_0000_0000_0D00;
   localparam logic [63:0] D1 = 64'hD111_1111_1111_1D11;
   localparam logic [63:0] D2 = 64'hD222_2222_2222_2D22;
   localparam logic [63:0] D3 = 64'hD333_3333_3333_3D33;
   localparam logic [63:0] B0 = 64'h0000_0000_B0B0_0001;
   localparam logic [63:0] B1 = 64'h0000_0000_B1B1_0002;
   localparam logic [63:0] B2 = 64'h0000_0000_B2B2_0003;
   localparam logic [63:0] B3 = 64'h0000_0000_B3B3_0004;
   localparam logic [63:0] C0 = 64'hC0C0_C0C0_0000_0010;
   localparam logic [63:0] C1 = 64'hC1C1_C1C1_0000_0020;
   localparam logic [63:0] C2 = 64'hC2C2_C2C2_0000_0030;
   localparam logic [63:0] C3 = 64'hC3C3_C3C3_0000_0040;

   initial begin
      logic [63:0] dbeat [4];
      dbeat[0] = D0; dbeat[1] = D1; dbeat[2] = D2; dbeat[3] = D3;

      rst_n       = 1'b0;
      line_read   = 1'b0;
      line_write  = 1'b0;
      line_addr   = 32'd0;
      line_wdata  = 256'd0;
      burst_rdata = 64'd0;
      burst_resp  = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      chk("rst_line_rdata", line_rdata, 256'd0);
      chk("rst_line_resp", line_resp, 1'b0);
      chk("rst_burst_read", burst_read, 1'b0);
      chk("rst_burst_write", burst_write, 1'b0);
      chk("rst_burst_addr", burst_addr, 32'd0);
      chk("rst_burst_wdata", burst_wdata, 64'd0);
      chk("rst_err", err, 1'b0);
      rst_n = 1'b1;
      tick();

      // Read at 0x1234, beats on consecutive cycles
      line_read = 1'b1;
      line_addr = 32'h0000_1234;
      tick();
      chk("rd_burst_addr", burst_addr, 32'h0000_1220);
      chk("rd_burst_write_low", burst_write, 1'b0);
      read_beats(A0, A1, A2, A3);
      chk("rd_resp_t5", line_resp, 1'b1);
      chk("rd_line_rdata", line_rdata, {A3, A2, A1, A0});
      chk("rd_burst_read_low_done", burst_read, 1'b0);
      line_read = 1'b0;
      tick();
      chk("rd_resp_one_cycle", line_resp, 1'b0);
      chk("rd_idle_no_burst", burst_read, 1'b0);

      // Write with two stall cycles before beats 1..3
      line_write = 1'b1;
      line_addr  = 32'h0000_5A5F;
      line_wdata = {D3, D2, D1, D0};
      t_acc      = cyc;
      tick();
      line_wdata = {4{64'hFFFF_FFFF_FFFF_FFFF}};
      chk("wr_burst_addr", burst_addr, 32'h0000_5A40);
      chk("wr_burst_read_low", burst_read, 1'b0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            for (int s = 0; s < 2; s++) begin
               burst_resp = 1'b0;
               chk("wr_stall_wdata_hold", burst_wdata, dbeat[k]);
               chk("wr_stall_burst_write", burst_write, 1'b1);
               tick();
            end
         end
         chk("wr_beat_wdata", burst_wdata, dbeat[k]);
         chk("wr_no_resp_yet", line_resp, 1'b0);
         burst_resp = 1'b1;
         tick();
      end
      burst_resp = 1'b0;
      chk("wr_resp", line_resp, 1'b1);
      chk("wr_latency_11", cyc - t_acc, 11);
      chk("wr_rdata_unchanged", line_rdata, {A3, A2, A1, A0});
      chk("wr_burst_write_low_done", burst_write, 1'b0);
      line_write = 1'b0;
      tick();
      chk("wr_resp_one_cycle", line_resp, 1'b0);

      // Spurious burst_resp in IDLE
      burst_resp  = 1'b1;
      burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      tick();
      burst_resp  = 1'b0;
      chk("spur_no_read", burst_read, 1'b0);
      chk("spur_no_write", burst_write, 1'b0);
      chk("spur_no_resp", line_resp, 1'b0);
      chk("spur_rdata_unchanged", line_rdata, {A3, A2, A1, A0});
      chk("spur_err", err, ERRCHK);
      tick();
      chk("spur_err_sticky", err, ERRCHK);

      // Both requests high: read wins
      line_read  = 1'b1;
      line_write = 1'b1;
      line_addr  = 32'h0000_4004;
      line_wdata = {4{64'h5555_5555_5555_5555}};
      tick();
      chk("both_burst_write_low", burst_write, 1'b0);
      chk("both_burst_addr", burst_addr, 32'h0000_4000);
      read_beats(B0, B1, B2, B3);
      chk("both_resp", line_resp, 1'b1);
      chk("both_rdata", line_rdata, {B3, B2, B1, B0});
      chk("both_err", err, ERRCHK);
      line_read  = 1'b0;
      line_write = 1'b0;
      tick();

      // Back-to-back reads, request held continuously
      line_read = 1'b1;
      line_addr = 32'h0000_1000;
      tick();
      read_beats(A3, A2, A1, A0);
      chk("b2b_first_resp", line_resp, 1'b1);
      chk("b2b_first_rdata", line_rdata, {A0, A1, A2, A3});
      line_addr = 32'h0000_2000;
      tick();
      chk("b2b_idle_gap_no_burst", burst_read, 1'b0);
      chk("b2b_idle_gap_no_resp", line_resp, 1'b0);
      tick();
      chk("b2b_second_accept", burst_read, 1'b1);
      chk("b2b_second_addr", burst_addr, 32'h0000_2000);
      read_beats(B0, B1, B2, B3);
      chk("b2b_second_resp", line_resp, 1'b1);
      chk("b2b_second_rdata", line_rdata, {B3, B2, B1, B0});
      line_read = 1'b0;
      tick();
      tick();
      chk("b2b_no_third_burst", burst_read, 1'b0);

      // Reset after beat 1 of a read
      line_read = 1'b1;
      line_addr = 32'h0000_7000;
      tick();
      burst_resp  = 1'b1;
      burst_rdata = C2;
      tick();
      burst_rdata = C3;
      tick();
      burst_resp  = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rdata", line_rdata, 256'd0);
      chk("mid_rst_burst_read", burst_read, 1'b0);
      chk("mid_rst_burst_addr", burst_addr, 32'd0);
      chk("mid_rst_resp", line_resp, 1'b0);
      chk("mid_rst_err", err, 1'b0);
      line_read = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_no_resume", burst_read, 1'b0);

      // Fresh read after reset
      line_read = 1'b1;
      line_addr = 32'h0000_8040;
      tick();
      chk("rec_burst_addr", burst_addr, 32'h0000_8040);
      read_beats(C0, C1, C2, C3);
      chk("rec_resp", line_resp, 1'b1);
      chk("rec_rdata", line_rdata, {C3, C2, C1, C0});
      chk("rec_err_clear", err, 1'b0);
      line_read = 1'b0;
      tick();
      chk("rec_resp_one_cycle", line_resp, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Memory-side responder for the cache `pmem_*` line interface. It accepts one 256-bit line read or write from a cache and converts it into a 4-beat, 64-bit burst transaction to main memory. It reassembles read beats into a full line and serialises write lines into beats. It sits between each cache (or the cache arbiter) and the physical memory model, and is the counterpart that generates `pmem_resp`/`pmem_rdata` for the cache controller.

## Interface

**Parameters**
- none

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_read` in 1: cache line read request. Held high until `line_resp`.
- `line_write` in 1: cache line write request. Held high until `line_resp`.
- `line_addr` in 32: line address. Bits [4:0] are ignored.
- `line_wdata` in 256: write line. Sampled at accept.
- `line_rdata` out 256: assembled read line.
- `line_resp` out 1: one-cycle completion pulse.
- `burst_read` out 1: memory burst read request.
- `burst_write` out 1: memory burst write request.
- `burst_addr` out 32: `{line_addr[31:5], 5'b0}`, registered at accept.
- `burst_wdata` out 64: current write beat.
- `burst_rdata` in 64: current read beat.
- `burst_resp` in 1: one beat transferred this cycle.
- `err` out 1: sticky protocol error. Only active when `CLADAPT_ERRCHK_EN` is defined.

## Operation

**States:** IDLE, RD, WR, DONE.

**IDLE**
- If `line_read`: latch the address, clear the beat counter, go to RD.
- Else if `line_write`: latch the address and `line_wdata` into the write buffer, clear the counter, go to WR.
- Read wins when both requests are high.

**RD**
- `burst_read` = 1.
- On each `burst_resp`: `line_rdata[64*k +: 64] <= burst_rdata`, where k is the 2-bit beat counter; then k increments.
- On the beat with k = 3 and `burst_resp`, go to DONE. The counter wraps to 0.

**WR**
- `burst_write` = 1; `burst_wdata` = `buf[64*k +: 64]`.
- `burst_resp` advances k. The beat with k = 3 and `burst_resp` goes to DONE.

**DONE**
- `line_resp` = 1 for exactly one cycle, then IDLE unconditionally.
- The cache drops its request on the same edge, so IDLE never re-accepts the finished request.

**Data rules**
- `line_rdata` is held stable from DONE until the next read is accepted.
- Writes never modify `line_rdata`.
- `burst_addr` is stable for the whole burst.
- Requests that change mid-burst are ignored. A request is only sampled in IDLE.
- A `burst_resp` arriving in IDLE or DONE is ignored.

## Timing

- Accept at edge T (IDLE sees a request).
- `burst_read`/`burst_write` are high from T+1 until the edge capturing beat 3.
- With `burst_resp` high every cycle, the beats land at T+1..T+4, DONE occupies T+5, and `line_resp` is visible in cycle T+5.
- Minimum request-to-resp latency is 5 cycles. Each memory stall cycle (`burst_resp` low) adds exactly one cycle.
- The next request can be accepted at T+6; back-to-back throughput is one line per 6 cycles.
- Outputs are registered-state decodes. `burst_wdata` is a mux of registered buffer and counter. Nothing combinational passes from `burst_*` inputs to outputs.

**Reset** (asynchronous, any state, including mid-burst)
- State returns to IDLE, counter = 0, buffer = 0.
- `line_rdata` = 0, `line_resp` = 0, `burst_read` = 0, `burst_write` = 0, `burst_addr` = 0, `burst_wdata` = 0, `err` = 0.
- The aborted burst is not resumed.

## Configuration

**`CLADAPT_ERRCHK_EN` defined**
- `err` sets on any `burst_resp` seen in IDLE or DONE, or on `line_read` and `line_write` both high in IDLE.
- It stays set until `rst_n` is asserted.
- Datapath behaviour is otherwise unchanged.

**Not defined**
- `err` is tied to 0 and no checker logic is built.

## Test plan

- Read line at `0x0000_1234`, memory answers beats `A0..A3` on consecutive cycles → `burst_addr` = `0x0000_1220`, `line_rdata` = `{A3,A2,A1,A0}`, `line_resp` exactly at T+5 for one cycle.
- Write line `{D3,D2,D1,D0}` with `burst_resp` gaps of 2 cycles between beats → `burst_wdata` presents D0, D1, D2, D3 in order, each held until its resp; `line_resp` arrives 5 + 6 = 11 cycles after accept; `line_rdata` is unchanged.
- `line_read` and `line_write` both high in IDLE → read burst performed, no write beats. With `CLADAPT_ERRCHK_EN`, `err` = 1.
- Back-to-back reads held high by the cache model, dropped on `line_resp` → exactly one burst per request, second accept at T+6.
- `rst_n` low after beat 1 of a read → all outputs go to 0 immediately. After release, a new read completes correctly with the counter restarting at beat 0.
- Spurious `burst_resp` in IDLE → no state change. With the macro, `err` is sticky at 1 until reset; without it, `err` stays 0.
